// File: rtl/test_pattern_checker.sv
`default_nettype none
// ============================================================================
//  Module      : test_pattern_checker
//  Description : Receive-side checker for the 4-bit test pattern generator.
//                Hunts for a seed sample and confirms a run of predicted
//                samples before declaring lock. It then verifies each sample
//                against a locally predicted word: STATIC_PATTERN in static
//                mode, or a free-running 4-bit LFSR in dynamic mode.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1   rising-edge clock
//    reset         in   1   asynchronous reset, active low
//    mode          in   1   0 = static word, 1 = LFSR sequence
//    pattern       in   4   sample under check
//    pattern_valid in   1   sample qualifier
//    clear_counts  in   1   synchronous clear of err_count / sample_count
//    locked        out  1   high while in LOCKED
//    error         out  1   one-cycle pulse per mismatching sample in LOCKED
//    err_count     out  8   saturating mismatch count while LOCKED
//    sample_count  out  16  saturating count of samples checked while LOCKED
// ============================================================================
module test_pattern_checker #(
  parameter logic [3:0]  STATIC_PATTERN = 4'b1010,
  parameter int unsigned LOCK_CNT       = 4,    // legal 2..15
  parameter int unsigned LOSS_CNT       = 3     // legal 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode,
  input  logic [3:0]  pattern,
  input  logic        pattern_valid,
  input  logic        clear_counts,
  output logic        locked,
  output logic        error,
  output logic [7:0]  err_count,
  output logic [15:0] sample_count
);

  localparam logic [3:0] c_lock_cnt = 4'(LOCK_CNT);
  localparam logic [3:0] c_loss_cnt = 4'(LOSS_CNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // LFSR successor, period 15; the all-zero word is a lock-up state.
  function automatic logic [3:0] lfsr_nxt(input logic [3:0] p);
    return {p[2:0], p[3] ^ p[2]};
  endfunction

  state_t      r_state;
  logic [3:0]  r_exp;
  logic [3:0]  r_run_cnt;
  logic [3:0]  r_miss_cnt;
  logic        r_mode_q;
  logic        r_error;
  logic [7:0]  r_err_count;
  logic [15:0] r_sample_count;

  state_t      w_state_nxt;
  state_t      w_eff_state;
  logic [3:0]  w_exp_nxt;
  logic [3:0]  w_run_nxt;
  logic [3:0]  w_miss_nxt;
  logic        w_mode_q_nxt;
  logic        w_error_nxt;
  logic [7:0]  w_err_count_nxt;
  logic [15:0] w_sample_count_nxt;
  logic        w_match;

  // In static mode r_exp is seeded with STATIC_PATTERN and never advanced,
  // so a single comparison serves both modes.
  assign w_match = (pattern == r_exp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_HUNT;
      r_exp          <= 4'd0;
      r_run_cnt      <= 4'd0;
      r_miss_cnt     <= 4'd0;
      r_mode_q       <= 1'b0;
      r_error        <= 1'b0;
      r_err_count    <= 8'd0;
      r_sample_count <= 16'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_exp          <= w_exp_nxt;
      r_run_cnt      <= w_run_nxt;
      r_miss_cnt     <= w_miss_nxt;
      r_mode_q       <= w_mode_q_nxt;
      r_error        <= w_error_nxt;
      r_err_count    <= w_err_count_nxt;
      r_sample_count <= w_sample_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_eff_state        = r_state;
    w_exp_nxt          = r_exp;
    w_run_nxt          = r_run_cnt;
    w_miss_nxt         = r_miss_cnt;
    w_mode_q_nxt       = r_mode_q;
    w_error_nxt        = 1'b0;
    w_err_count_nxt    = r_err_count;
    w_sample_count_nxt = r_sample_count;

    if (pattern_valid) begin
      w_mode_q_nxt = mode;
      // A mode change invalidates any prediction: treat the sample as a
      // fresh HUNT candidate whatever state we were in.
      w_eff_state  = (mode != r_mode_q) ? ST_HUNT : r_state;

      case (w_eff_state)
        ST_VERIFY: begin
          if (mode) begin
            w_exp_nxt = lfsr_nxt(r_exp);
          end
          if (w_match) begin
            w_run_nxt = r_run_cnt + 4'd1;
            if (r_run_cnt + 4'd1 == c_lock_cnt) begin
              w_state_nxt = ST_LOCKED;
              w_miss_nxt  = 4'd0;
            end else begin
              w_state_nxt = ST_VERIFY;
            end
          end else begin
            // Bad sample aborts the run; it is not trusted as a new seed.
            w_state_nxt = ST_HUNT;
          end
        end

        ST_LOCKED: begin
          // Free-run the predictor so a corrupted sample cannot re-seed it.
          if (mode) begin
            w_exp_nxt = lfsr_nxt(r_exp);
          end
          if (r_sample_count != 16'hFFFF) begin
            w_sample_count_nxt = r_sample_count + 16'd1;
          end
          if (w_match) begin
            w_miss_nxt  = 4'd0;
            w_state_nxt = ST_LOCKED;
          end else begin
            w_error_nxt = 1'b1;
            if (r_err_count != 8'hFF) begin
              w_err_count_nxt = r_err_count + 8'd1;
            end
            w_miss_nxt = r_miss_cnt + 4'd1;
            if (r_miss_cnt + 4'd1 == c_loss_cnt) begin
              w_state_nxt = ST_HUNT;
            end else begin
              w_state_nxt = ST_LOCKED;
            end
          end
        end

        default: begin
          // HUNT: look for a usable seed sample.
          w_state_nxt = ST_HUNT;
          if (!mode && (pattern == STATIC_PATTERN)) begin
            w_exp_nxt   = STATIC_PATTERN;
            w_run_nxt   = 4'd1;
            w_state_nxt = ST_VERIFY;
          end else if (mode && (pattern != 4'd0)) begin
            w_exp_nxt   = lfsr_nxt(pattern);
            w_run_nxt   = 4'd1;
            w_state_nxt = ST_VERIFY;
          end
        end
      endcase
    end

    // Clear takes priority over any increment at the same edge.
    if (clear_counts) begin
      w_err_count_nxt    = 8'd0;
      w_sample_count_nxt = 16'd0;
    end
  end

  assign locked       = (r_state == ST_LOCKED);
  assign error        = r_error;
  assign err_count    = r_err_count;
  assign sample_count = r_sample_count;

endmodule
`default_nettype wire
